// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator: FSM/action encodings and note constants.
package synth_pkg;

  localparam int unsigned NOTE_WIDTH_DEFAULT = 7;

  // ReqOn encoding
  localparam logic NOTE_ON  = 1'b1;
  localparam logic NOTE_OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  // Action decided in SCAN and applied in COMMIT
  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_OFF  = 2'd2
  } alloc_act_e;

endpackage

// File: rtl/voice_lru.sv
// Least-recently-assigned tracker: one age register per voice, age 0 = newest.
// Ports:
//   Clock, Reset   clock, synchronous active-low reset
//   update         strobe: target voice was just assigned
//   target         index of the assigned voice
//   oldest_c       one-hot flag of the voice with age NUM_VOICES-1
module voice_lru #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VIDX_WIDTH = $clog2(NUM_VOICES)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  update,
  input  logic [VIDX_WIDTH-1:0] target,
  output logic [NUM_VOICES-1:0] oldest_c
);

  logic [VIDX_WIDTH-1:0] age_q [NUM_VOICES];

  // Move target to age 0; everything younger than it ages by one, keeping a permutation.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= VIDX_WIDTH'(i);
    end else if (update) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (VIDX_WIDTH'(i) == target)      age_q[i] <= '0;
        else if (age_q[i] < age_q[target]) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    oldest_c = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      oldest_c[i] = (age_q[i] == VIDX_WIDTH'(NUM_VOICES - 1));
  end

endmodule

// File: rtl/adsr_voice_allocator.sv
// Allocates ADSR envelope voices to note-on/note-off requests, stealing the
// least-recently-assigned voice when the pool is full.
// Ports:
//   Clock, Reset          clock, synchronous active-low reset
//   ReqValid/ReqOn/ReqNote/ReqReady   request handshake (one request per 3 cycles)
//   VoiceIdle            per-voice envelope-finished status
//   VoiceGate            per-voice note-held gate
//   VoiceTrigger         per-voice one-cycle envelope restart pulse
//   VoiceNote            per-voice assigned note, voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
//   LastVoice            voice touched by the most recent committed request
module adsr_voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_WIDTH = NOTE_WIDTH_DEFAULT,
  parameter int unsigned VIDX_WIDTH = $clog2(NUM_VOICES)
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             ReqValid,
  input  logic                             ReqOn,
  input  logic [NOTE_WIDTH-1:0]            ReqNote,
  output logic                             ReqReady,
  input  logic [NUM_VOICES-1:0]            VoiceIdle,
  output logic [NUM_VOICES-1:0]            VoiceGate,
  output logic [NUM_VOICES-1:0]            VoiceTrigger,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] VoiceNote,
  output logic [VIDX_WIDTH-1:0]            LastVoice
);

  alloc_state_e                    state_q, state_d;
  alloc_act_e                      act_q, act_d, scan_act_c;
  logic                            ready_q, ready_d;
  logic                            req_on_q, req_on_d;
  logic [NOTE_WIDTH-1:0]           req_note_q, req_note_d;
  logic [NUM_VOICES-1:0]           gate_q, gate_d, trig_q, trig_d;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] note_q, note_d;
  logic [VIDX_WIDTH-1:0]           last_q, last_d, tgt_q, tgt_d, scan_tgt_c;
  logic [NUM_VOICES-1:0]           oldest_c;
  logic                            lru_upd_c;

  assign lru_upd_c = (state_q == ST_COMMIT) && (act_q == ACT_ON);

  voice_lru #(
    .NUM_VOICES (NUM_VOICES),
    .VIDX_WIDTH (VIDX_WIDTH)
  ) u_lru (
    .Clock    (Clock),
    .Reset    (Reset),
    .update   (lru_upd_c),
    .target   (tgt_q),
    .oldest_c (oldest_c)
  );

  // Priority encoders over the registered voice state; descending loop so the lowest index wins.
  always_comb begin
    logic                  has_match, has_idle, has_rel;
    logic [VIDX_WIDTH-1:0] idx_match, idx_idle, idx_rel, idx_old;
    has_match  = 1'b0;
    has_idle   = 1'b0;
    has_rel    = 1'b0;
    idx_match  = '0;
    idx_idle   = '0;
    idx_rel    = '0;
    idx_old    = '0;
    scan_act_c = ACT_NONE;
    scan_tgt_c = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i*NOTE_WIDTH +: NOTE_WIDTH] == req_note_q)) begin
        has_match = 1'b1;
        idx_match = VIDX_WIDTH'(i);
      end
      if (!gate_q[i] && VoiceIdle[i]) begin
        has_idle = 1'b1;
        idx_idle = VIDX_WIDTH'(i);
      end
      if (!gate_q[i]) begin
        has_rel = 1'b1;
        idx_rel = VIDX_WIDTH'(i);
      end
      if (oldest_c[i]) idx_old = VIDX_WIDTH'(i);
    end
    if (req_on_q == NOTE_ON) begin
      scan_act_c = ACT_ON;
      if (has_match)     scan_tgt_c = idx_match;
      else if (has_idle) scan_tgt_c = idx_idle;
      else if (has_rel)  scan_tgt_c = idx_rel;
      else               scan_tgt_c = idx_old;
    end else if (has_match) begin
      scan_act_c = ACT_OFF;
      scan_tgt_c = idx_match;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    ready_d    = ready_q;
    req_on_d   = req_on_q;
    req_note_d = req_note_q;
    gate_d     = gate_q;
    trig_d     = '0;
    note_d     = note_q;
    last_d     = last_q;
    tgt_d      = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid && ready_q) begin
          req_on_d   = ReqOn;
          req_note_d = ReqNote;
          ready_d    = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        act_d   = scan_act_c;
        tgt_d   = scan_tgt_c;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
        if (act_q == ACT_ON) begin
          gate_d[tgt_q] = 1'b1;
          trig_d[tgt_q] = 1'b1;
          note_d[int'(tgt_q)*NOTE_WIDTH +: NOTE_WIDTH] = req_note_q;
          last_d = tgt_q;
        end else if (act_q == ACT_OFF) begin
          gate_d[tgt_q] = 1'b0;
          last_d = tgt_q;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      act_q      <= ACT_NONE;
      ready_q    <= 1'b1;
      req_on_q   <= NOTE_OFF;
      req_note_q <= '0;
      gate_q     <= '0;
      trig_q     <= '0;
      note_q     <= '0;
      last_q     <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      ready_q    <= ready_d;
      req_on_q   <= req_on_d;
      req_note_q <= req_note_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      note_q     <= note_d;
      last_q     <= last_d;
      tgt_q      <= tgt_d;
    end
  end

  assign ReqReady     = ready_q;
  assign VoiceGate    = gate_q;
  assign VoiceTrigger = trig_q;
  assign VoiceNote    = note_q;
  assign LastVoice    = last_q;

endmodule

// File: tb/tb_adsr_voice_allocator.sv
// Directed bench for adsr_voice_allocator (4 voices, 7-bit notes).
module tb_adsr_voice_allocator;

  localparam int unsigned NV = 4;
  localparam int unsigned NW = 7;
  localparam int unsigned VW = 2;

  logic          Clock;
  logic          Reset;
  logic          ReqValid;
  logic          ReqOn;
  logic [NW-1:0] ReqNote;
  logic          ReqReady;
  logic [NV-1:0] VoiceIdle;
  logic [NV-1:0] VoiceGate;
  logic [NV-1:0] VoiceTrigger;
  logic [NV*NW-1:0] VoiceNote;
  logic [VW-1:0] LastVoice;

  int vectors = 0;
  int miscompares = 0;

  adsr_voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .VIDX_WIDTH(VW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqOn        (ReqOn),
    .ReqNote      (ReqNote),
    .ReqReady     (ReqReady),
    .VoiceIdle    (VoiceIdle),
    .VoiceGate    (VoiceGate),
    .VoiceTrigger (VoiceTrigger),
    .VoiceNote    (VoiceNote),
    .LastVoice    (LastVoice)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] notes(input int n3, input int n2, input int n1, input int n0);
    return 32'({NW'(n3), NW'(n2), NW'(n1), NW'(n0)});
  endfunction

  task automatic check_ages(input string tag, input int a0, input int a1, input int a2, input int a3);
    check({tag, "_age0"}, 32'(dut.u_lru.age_q[0]), 32'(a0));
    check({tag, "_age1"}, 32'(dut.u_lru.age_q[1]), 32'(a1));
    check({tag, "_age2"}, 32'(dut.u_lru.age_q[2]), 32'(a2));
    check({tag, "_age3"}, 32'(dut.u_lru.age_q[3]), 32'(a3));
  endtask

  // Issue one request and follow it to the cycle its outputs appear.
  task automatic send(input string tag, input logic on, input int note);
    check({tag, "_ready_pre"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1;
    ReqOn    = on;
    ReqNote  = NW'(note);
    @(negedge Clock);
    ReqValid = 1'b0;
    ReqOn    = 1'b0;
    ReqNote  = '0;
    check({tag, "_busy1"}, 32'(ReqReady), 32'd0);
    @(negedge Clock);
    check({tag, "_busy2"}, 32'(ReqReady), 32'd0);
    @(negedge Clock);
    check({tag, "_ready_post"}, 32'(ReqReady), 32'd1);
  endtask

  // Outputs at the commit-visible cycle, then the trigger must be gone one cycle later.
  task automatic expect_out(input string tag, input logic [3:0] gate, input logic [3:0] trig,
                            input logic [31:0] nv, input int last);
    check({tag, "_gate"}, 32'(VoiceGate), 32'(gate));
    check({tag, "_trig"}, 32'(VoiceTrigger), 32'(trig));
    check({tag, "_note"}, 32'(VoiceNote), nv);
    check({tag, "_last"}, 32'(LastVoice), 32'(last));
    @(negedge Clock);
    check({tag, "_trig_end"}, 32'(VoiceTrigger), 32'd0);
  endtask

  initial begin
    Reset     = 1'b0;
    ReqValid  = 1'b0;
    ReqOn     = 1'b0;
    ReqNote   = '0;
    VoiceIdle = 4'b1111;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_gate", 32'(VoiceGate), 32'd0);
    check("rst_trig", 32'(VoiceTrigger), 32'd0);
    check("rst_note", 32'(VoiceNote), 32'd0);
    check("rst_last", 32'(LastVoice), 32'd0);
    check("rst_ready", 32'(ReqReady), 32'd1);
    check_ages("rst", 0, 1, 2, 3);
    Reset = 1'b1;
    @(negedge Clock);

    // Fill the pool
    send("on60", 1'b1, 60);
    expect_out("on60", 4'b0001, 4'b0001, notes(0, 0, 0, 60), 0);
    send("on62", 1'b1, 62);
    expect_out("on62", 4'b0011, 4'b0010, notes(0, 0, 62, 60), 1);
    send("on64", 1'b1, 64);
    expect_out("on64", 4'b0111, 4'b0100, notes(0, 64, 62, 60), 2);
    send("on67", 1'b1, 67);
    expect_out("on67", 4'b1111, 4'b1000, notes(67, 64, 62, 60), 3);
    check_ages("full", 3, 2, 1, 0);

    // Pool exhausted: steal oldest (voice 0)
    send("steal69", 1'b1, 69);
    expect_out("steal69", 4'b1111, 4'b0001, notes(67, 64, 62, 69), 0);
    check_ages("steal69", 0, 3, 2, 1);

    // Note-off of a held note, then of an unheld note
    send("off62", 1'b0, 62);
    expect_out("off62", 4'b1101, 4'b0000, notes(67, 64, 62, 69), 1);
    send("off50", 1'b0, 50);
    expect_out("off50", 4'b1101, 4'b0000, notes(67, 64, 62, 69), 1);
    check_ages("offs", 0, 3, 2, 1);

    // Voice 0 releasing, voice 1 idle: idle wins
    send("off69", 1'b0, 69);
    expect_out("off69", 4'b1100, 4'b0000, notes(67, 64, 62, 69), 0);
    VoiceIdle = 4'b0010;
    send("on72", 1'b1, 72);
    expect_out("on72", 4'b1110, 4'b0010, notes(67, 64, 72, 69), 1);
    check_ages("on72", 1, 0, 3, 2);

    // Nothing idle: take lowest releasing voice
    VoiceIdle = 4'b0000;
    send("on74", 1'b1, 74);
    expect_out("on74", 4'b1111, 4'b0001, notes(67, 64, 72, 74), 0);
    check_ages("on74", 0, 1, 3, 2);

    // Retrigger voice already holding the note
    send("re64", 1'b1, 64);
    expect_out("re64", 4'b1111, 4'b0100, notes(67, 64, 72, 74), 2);
    check_ages("re64", 1, 2, 0, 3);

    // Second steal picks voice 3
    send("steal80", 1'b1, 80);
    expect_out("steal80", 4'b1111, 4'b1000, notes(80, 64, 72, 74), 3);
    check_ages("steal80", 2, 3, 1, 0);

    // Reset asserted while a note-on sits in COMMIT
    ReqValid = 1'b1;
    ReqOn    = 1'b1;
    ReqNote  = NW'(90);
    @(negedge Clock);
    ReqValid = 1'b0;
    check("rstc_scan_busy", 32'(ReqReady), 32'd0);
    @(negedge Clock);
    check("rstc_commit_busy", 32'(ReqReady), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rstc_gate", 32'(VoiceGate), 32'd0);
    check("rstc_trig", 32'(VoiceTrigger), 32'd0);
    check("rstc_note", 32'(VoiceNote), 32'd0);
    check("rstc_last", 32'(LastVoice), 32'd0);
    check("rstc_ready", 32'(ReqReady), 32'd1);
    check_ages("rstc", 0, 1, 2, 3);
    Reset = 1'b1;
    @(negedge Clock);
    check("rstc_trig_after", 32'(VoiceTrigger), 32'd0);

    // After reset: hold 60/62 then release 60
    VoiceIdle = 4'b1111;
    send("p_on60", 1'b1, 60);
    expect_out("p_on60", 4'b0001, 4'b0001, notes(0, 0, 0, 60), 0);
    send("p_on62", 1'b1, 62);
    expect_out("p_on62", 4'b0011, 4'b0010, notes(0, 0, 62, 60), 1);
    send("p_off60", 1'b0, 60);
    expect_out("p_off60", 4'b0010, 4'b0000, notes(0, 0, 62, 60), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
